// File: rtl/pe_layer_cfg_seq.sv
// Per-PE DNN layer configuration register file with a built-in layer sequencer.
// Holds the layer count and per-layer activation counts, written over the boot-time
// configuration path, then steps through the layers on controller handshakes and
// presents registered in/out activation counts to the PE datapath.
module pe_layer_cfg_seq #(
   parameter int PE_IDX    = 0,
   parameter int MAX_LAYER = 8,
   parameter int ACT_W     = 6,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 5,
   localparam int LAYER_W  = $clog2(MAX_LAYER + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               write_en,
   input  logic [ADDR_W-1:0]  write_addr,
   input  logic [DATA_W-1:0]  write_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [DATA_W-1:0]  rd_data,
   output logic               rd_valid,
   input  logic               start,
   input  logic               layer_done,
   input  logic               err_clr,
   output logic               busy,
   output logic               done,
   output logic [LAYER_W-1:0] layer_idx,
   output logic [LAYER_W-1:0] layer_no,
   output logic [ACT_W-1:0]   in_act_no,
   output logic [ACT_W-1:0]   out_act_no,
   output logic               cfg_err
);

   // Last address of the activation table (addr 1 .. MAX_LAYER+1).
   localparam logic [ADDR_W-1:0] ACT_LAST = ADDR_W'(MAX_LAYER + 1);

   // PE_IDX only tags instances; a negative index has no meaning and builds nothing.
   if (PE_IDX < 0) begin : g_pe_idx_neg
   end

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [LAYER_W-1:0] layer_no_q, layer_no_d;
   logic [LAYER_W-1:0] idx_q, idx_d;
   logic [LAYER_W-1:0] idx_p1, idx_p2;
   logic [ACT_W-1:0]   act_q [MAX_LAYER+1];
   logic [ACT_W-1:0]   in_q, in_d, out_q, out_d;
   logic               err_q, err_d, err_set;
   logic               busy_q, done_q;
   logic               act_we;
   logic [LAYER_W-1:0] act_widx, act_ridx;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;
   logic               rd_valid_q;

   // idx+1 and idx+2 stay within the table: idx < layer_no-1 whenever idx+2 is used.
   assign idx_p1   = idx_q + LAYER_W'(1);
   assign idx_p2   = idx_q + LAYER_W'(2);
   assign act_widx = LAYER_W'(write_addr - ADDR_W'(1));
   assign act_ridx = LAYER_W'(rd_addr - ADDR_W'(1));

   // Next-state: config writes, sequencer transitions and sticky error.
   always_comb begin
      state_d    = state_q;
      layer_no_d = layer_no_q;
      idx_d      = idx_q;
      in_d       = in_q;
      out_d      = out_q;
      err_set    = 1'b0;
      act_we     = 1'b0;

      // Writes only land while idle; the sequencer below reads pre-write values.
      if (write_en) begin
         if (state_q != S_IDLE) begin
            err_set = 1'b1;
         end else if (write_addr == '0) begin
            if (write_data > DATA_W'(MAX_LAYER)) err_set = 1'b1;
            else layer_no_d = write_data[LAYER_W-1:0];
         end else if (write_addr <= ACT_LAST) begin
            act_we = 1'b1;
         end else begin
            err_set = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (layer_no_q == '0) begin
                  err_set = 1'b1;
               end else begin
                  state_d = S_RUN;
                  idx_d   = '0;
                  in_d    = act_q[0];
                  out_d   = act_q[1];
               end
            end
         end
         S_RUN: begin
            if (layer_done) begin
               if (idx_q == layer_no_q - LAYER_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_p1;
                  in_d  = act_q[idx_p1];
                  out_d = act_q[idx_p2];
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // A new error on the same edge as a clear keeps the flag set.
      if (err_set)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;
      else              err_d = err_q;
   end

   // Read-back mux: unmapped addresses return zero.
   always_comb begin
      rd_data_d = '0;
      if (rd_addr == '0)          rd_data_d = DATA_W'(layer_no_q);
      else if (rd_addr <= ACT_LAST) rd_data_d = DATA_W'(act_q[act_ridx]);
   end

   // Control and sequencer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         layer_no_q <= '0;
         idx_q      <= '0;
         in_q       <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         layer_no_q <= layer_no_d;
         idx_q      <= idx_d;
         in_q       <= in_d;
         out_q      <= out_d;
         err_q      <= err_d;
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
      end
   end

   // Activation-count table.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= MAX_LAYER; i++) act_q[i] <= '0;
      end else if (act_we) begin
         act_q[act_widx] <= write_data[ACT_W-1:0];
      end
   end

   // Read-back port with one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= rd_data_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign layer_idx  = idx_q;
   assign layer_no   = layer_no_q;
   assign in_act_no  = in_q;
   assign out_act_no = out_q;
   assign cfg_err    = err_q;

endmodule
